mac_slice_acc: RTL and testbench

//   Parametrised, handshaked slice-serial multiply-accumulate for the BDD accelerator datapath.

---
 rtl/mac_pkg.sv | 27 ++
 rtl/mac_slice_acc_if.sv | 27 ++
 rtl/mac_slice_mul.sv | 33 +++
 rtl/mac_slice_acc.sv | 145 ++++++++++++++
 tb/tb_mac_slice_acc.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/mac_pkg.sv
// Shared types and elaboration-time helpers for the slice-serial MAC.
package mac_pkg;

    // Controller states: wait for a word, run its slices, hold a result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        HOLD = 2'd2
    } state_e;

    // Number of slices per attribute/coefficient word.
    function automatic int unsigned num_slices(input int unsigned attr_w,
                                               input int unsigned slice_w);
        return attr_w / slice_w;
    endfunction

    // Counter width for n states; never narrower than one bit.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/mac_slice_acc_if.sv
// Word-in / result-out handshake bundle for mac_slice_acc.
interface mac_slice_acc_if #(
    parameter int unsigned ATTR_WIDTH = 24,
    parameter int unsigned ACC_WIDTH  = 20
);
    logic                  in_valid;
    logic                  in_ready;
    logic [ATTR_WIDTH-1:0] in_attr;
    logic [ATTR_WIDTH-1:0] in_coef;
    logic                  in_last;
    logic                  out_valid;
    logic                  out_ready;
    logic [ACC_WIDTH-1:0]  out_acc;
    logic                  out_ovf;

    // Producer of words and consumer of results.
    modport master (
        output in_valid, in_attr, in_coef, in_last, out_ready,
        input  in_ready, out_valid, out_acc, out_ovf
    );

    // The MAC itself.
    modport slave (
        input  in_valid, in_attr, in_coef, in_last, out_ready,
        output in_ready, out_valid, out_acc, out_ovf
    );
endinterface

// File: rtl/mac_slice_mul.sv
// Combinational slice multiplier; product extended to the accumulator width.
module mac_slice_mul #(
    parameter int unsigned SLICE_WIDTH = 8,
    parameter int unsigned ACC_WIDTH   = 20,
    parameter int unsigned SIGNED      = 0
) (
    input  logic [SLICE_WIDTH-1:0] a,
    input  logic [SLICE_WIDTH-1:0] b,
    output logic [ACC_WIDTH-1:0]   prod
);
    localparam int unsigned PW = 2 * SLICE_WIDTH;

    logic          sa;
    logic          sb;
    logic [PW-1:0] p;

    // Extend operands to the full product width first; the low PW bits of the
    // wide product are then exact for both signed and unsigned slices.
    always_comb begin
        sa = (SIGNED != 0) ? a[SLICE_WIDTH-1] : 1'b0;
        sb = (SIGNED != 0) ? b[SLICE_WIDTH-1] : 1'b0;
        p  = {{SLICE_WIDTH{sa}}, a} * {{SLICE_WIDTH{sb}}, b};
    end

    if (ACC_WIDTH > PW) begin : g_ext
        logic ext_bit;
        assign ext_bit = (SIGNED != 0) ? p[PW-1] : 1'b0;
        assign prod    = {{(ACC_WIDTH - PW){ext_bit}}, p};
    end else begin : g_noext
        assign prod = p[ACC_WIDTH-1:0];
    end

endmodule

// File: rtl/mac_slice_acc.sv
// Slice-serial multiply-accumulate: one slice pair per cycle, MSB slice first,
// accumulating across words until a word flagged last, then holding the result.
// Optional build macro MAC_SAT_EN: saturate the accumulator on overflow instead of wrapping.
module mac_slice_acc
    import mac_pkg::*;
#(
    parameter int unsigned ATTR_WIDTH  = 24,
    parameter int unsigned SLICE_WIDTH = 8,
    parameter int unsigned ACC_WIDTH   = 20,
    parameter int unsigned SIGNED      = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  acc_clr,
    mac_slice_acc_if.slave        bus,
    output logic                  busy
);
    localparam int unsigned NUM_SLICES = num_slices(ATTR_WIDTH, SLICE_WIDTH);
    localparam int unsigned CNT_W      = clog2(NUM_SLICES);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_SLICES - 1);

    state_e                state_q;
    logic [ACC_WIDTH-1:0]  acc_q;
    logic [CNT_W-1:0]      slice_cnt_q;
    logic [ATTR_WIDTH-1:0] attr_q;
    logic [ATTR_WIDTH-1:0] coef_q;
    logic                  last_q;
    logic                  ovf_q;
    logic [ACC_WIDTH-1:0]  out_acc_q;
    logic                  out_ovf_q;
    logic                  out_valid_q;

    logic [ACC_WIDTH-1:0]  prod;
    logic [ACC_WIDTH:0]    sum_w;
    logic [ACC_WIDTH-1:0]  sum;
    logic                  step_ovf;
    logic [ACC_WIDTH-1:0]  acc_next;

    // Word registers shift left each MAC cycle, so the current slice is always on top.
    mac_slice_mul #(
        .SLICE_WIDTH (SLICE_WIDTH),
        .ACC_WIDTH   (ACC_WIDTH),
        .SIGNED      (SIGNED)
    ) u_mul (
        .a    (attr_q[ATTR_WIDTH-1 -: SLICE_WIDTH]),
        .b    (coef_q[ATTR_WIDTH-1 -: SLICE_WIDTH]),
        .prod (prod)
    );

    // Accumulate step: wrapped sum, overflow detect and optional clamp.
    always_comb begin
        sum_w = {1'b0, acc_q} + {1'b0, prod};
        sum   = sum_w[ACC_WIDTH-1:0];
        if (SIGNED != 0) begin
            step_ovf = (acc_q[ACC_WIDTH-1] == prod[ACC_WIDTH-1]) &&
                       (sum[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]);
        end else begin
            step_ovf = sum_w[ACC_WIDTH];
        end
`ifdef MAC_SAT_EN
        acc_next = sum;
        if (step_ovf) begin
            if (SIGNED == 0) begin
                acc_next = '1;
            end else if (prod[ACC_WIDTH-1]) begin
                acc_next = {1'b1, {(ACC_WIDTH - 1){1'b0}}};
            end else begin
                acc_next = {1'b0, {(ACC_WIDTH - 1){1'b1}}};
            end
        end
`else
        acc_next = sum;
`endif
    end

    // Controller and datapath registers; acc_clr overrides every handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            slice_cnt_q <= '0;
            attr_q      <= '0;
            coef_q      <= '0;
            last_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_acc_q   <= '0;
            out_ovf_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (acc_clr) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            slice_cnt_q <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        attr_q      <= bus.in_attr;
                        coef_q      <= bus.in_coef;
                        last_q      <= bus.in_last;
                        slice_cnt_q <= '0;
                        state_q     <= MAC;
                    end
                end
                MAC: begin
                    attr_q      <= attr_q << SLICE_WIDTH;
                    coef_q      <= coef_q << SLICE_WIDTH;
                    slice_cnt_q <= slice_cnt_q + CNT_W'(1);
                    if (slice_cnt_q == LAST_CNT && last_q) begin
                        out_acc_q   <= acc_next;
                        out_ovf_q   <= ovf_q | step_ovf;
                        out_valid_q <= 1'b1;
                        acc_q       <= '0;
                        ovf_q       <= 1'b0;
                        state_q     <= HOLD;
                    end else begin
                        acc_q <= acc_next;
                        ovf_q <= ovf_q | step_ovf;
                        if (slice_cnt_q == LAST_CNT) begin
                            state_q <= IDLE;
                        end
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Handshake and status outputs.
    always_comb begin
        bus.in_ready  = (state_q == IDLE) && !acc_clr;
        bus.out_valid = out_valid_q;
        bus.out_acc   = out_acc_q;
        bus.out_ovf   = out_ovf_q;
        busy          = (state_q != IDLE);
    end

endmodule

// File: tb/tb_mac_slice_acc.sv
// Directed bench for mac_slice_acc: an unsigned and a signed instance share stimulus.
module tb_mac_slice_acc;
    localparam int unsigned AW = 24;
    localparam int unsigned SW = 8;
    localparam int unsigned CW = 20;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          acc_clr;
    logic          in_valid;
    logic          in_last;
    logic          out_ready;
    logic [AW-1:0] in_attr;
    logic [AW-1:0] in_coef;
    logic          busy_u;
    logic          busy_s;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc;
    int seen;

    always #5 clk = ~clk;

    mac_slice_acc_if #(.ATTR_WIDTH(AW), .ACC_WIDTH(CW)) bus_u ();
    mac_slice_acc_if #(.ATTR_WIDTH(AW), .ACC_WIDTH(CW)) bus_s ();

    assign bus_u.in_valid  = in_valid;
    assign bus_u.in_attr   = in_attr;
    assign bus_u.in_coef   = in_coef;
    assign bus_u.in_last   = in_last;
    assign bus_u.out_ready = out_ready;
    assign bus_s.in_valid  = in_valid;
    assign bus_s.in_attr   = in_attr;
    assign bus_s.in_coef   = in_coef;
    assign bus_s.in_last   = in_last;
    assign bus_s.out_ready = out_ready;

    mac_slice_acc #(
        .ATTR_WIDTH (AW), .SLICE_WIDTH (SW), .ACC_WIDTH (CW), .SIGNED (0)
    ) u_dut (
        .clk (clk), .rst_n (rst_n), .acc_clr (acc_clr), .bus (bus_u), .busy (busy_u)
    );

    mac_slice_acc #(
        .ATTR_WIDTH (AW), .SLICE_WIDTH (SW), .ACC_WIDTH (CW), .SIGNED (1)
    ) u_dut_s (
        .clk (clk), .rst_n (rst_n), .acc_clr (acc_clr), .bus (bus_s), .busy (busy_s)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present a word and hold it until accepted; returns at the negedge after acceptance.
    task automatic send(input logic [AW-1:0] a, input logic [AW-1:0] c, input logic l);
        int n;
        @(negedge clk);
        in_valid = 1'b1;
        in_attr  = a;
        in_coef  = c;
        in_last  = l;
        n = 0;
        while (!bus_u.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("send_ready", 32'(bus_u.in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_attr  = 24'hA5A5A5;
        in_coef  = 24'h5A5A5A;
        in_last  = ~l;
    endtask

    task automatic wait_res(output int c);
        c = 0;
        while (!bus_u.out_valid && c < 20) begin
            @(negedge clk);
            c++;
        end
    endtask

    task automatic pop();
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b1; acc_clr = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        in_attr = '0; in_coef = '0; out_ready = 1'b0;
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 32'(bus_u.out_valid), 32'd0);
        check("rst_out_acc", 32'(bus_u.out_acc), 32'd0);
        check("rst_out_ovf", 32'(bus_u.out_ovf), 32'd0);
        check("rst_busy", 32'(busy_u), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("rst_in_ready", 32'(bus_u.in_ready), 32'd1);

        // Unsigned dot product, 3-cycle latency.
        send(24'h010203, 24'h040506, 1'b1);
        wait_res(cyc);
        check("t1_latency", 32'(cyc), 32'd3);
        check("t1_acc", 32'(bus_u.out_acc), 32'h00020);
        check("t1_ovf", 32'(bus_u.out_ovf), 32'd0);

        // Backpressure: result held while out_ready stays low.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", 32'(bus_u.out_valid), 32'd1);
            check("bp_acc", 32'(bus_u.out_acc), 32'h00020);
            check("bp_in_ready", 32'(bus_u.in_ready), 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_release_valid", 32'(bus_u.out_valid), 32'd0);
        check("bp_release_busy", 32'(busy_u), 32'd0);
        check("bp_release_ready", 32'(bus_u.in_ready), 32'd1);

        // Two-word chain, single result.
        send(24'h010101, 24'h010101, 1'b0);
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            seen += int'(bus_u.out_valid);
            @(negedge clk);
        end
        check("t2_no_early_valid", 32'(seen), 32'd0);
        send(24'h020202, 24'h030303, 1'b1);
        wait_res(cyc);
        check("t2_valid", 32'(bus_u.out_valid), 32'd1);
        check("t2_acc", 32'(bus_u.out_acc), 32'h00015);
        check("t2_ovf", 32'(bus_u.out_ovf), 32'd0);
        pop();

        // Overflow across six chained all-ones words.
        for (int i = 0; i < 6; i++) begin
            send(24'hFFFFFF, 24'hFFFFFF, (i == 5));
        end
        wait_res(cyc);
        check("t4_valid", 32'(bus_u.out_valid), 32'd1);
`ifdef MAC_SAT_EN
        check("t4_acc", 32'(bus_u.out_acc), 32'hFFFFF);
`else
        check("t4_acc", 32'(bus_u.out_acc), 32'h1DC12);
`endif
        check("t4_ovf", 32'(bus_u.out_ovf), 32'd1);
        pop();

        // Next group starts clean: no carried sum or sticky overflow.
        send(24'h010203, 24'h040506, 1'b1);
        wait_res(cyc);
        check("t4_after_acc", 32'(bus_u.out_acc), 32'h00020);
        check("t4_after_ovf", 32'(bus_u.out_ovf), 32'd0);
        pop();

        // Signed slices: -1 * 2 = -2; unsigned instance sees 255 * 2.
        send(24'hFF0000, 24'h020000, 1'b1);
        wait_res(cyc);
        check("t5_s_acc", 32'(bus_s.out_acc), 32'hFFFFE);
        check("t5_s_ovf", 32'(bus_s.out_ovf), 32'd0);
        check("t5_u_acc", 32'(bus_u.out_acc), 32'h001FE);
        pop();

        // Abort mid-MAC, then the next group starts from zero.
        send(24'h010203, 24'h040506, 1'b1);
        acc_clr = 1'b1;
        #1 check("clr_in_ready", 32'(bus_u.in_ready), 32'd0);
        @(negedge clk);
        acc_clr = 1'b0;
        check("clr_busy", 32'(busy_u), 32'd0);
        check("clr_valid", 32'(bus_u.out_valid), 32'd0);
        // Word offered together with acc_clr is refused.
        in_valid = 1'b1; in_attr = 24'h070707; in_coef = 24'h070707; in_last = 1'b1;
        acc_clr  = 1'b1;
        #1 check("clr_vs_valid_ready", 32'(bus_u.in_ready), 32'd0);
        @(negedge clk);
        in_valid = 1'b0; acc_clr = 1'b0;
        check("clr_vs_valid_busy", 32'(busy_u), 32'd0);
        send(24'h010101, 24'h010101, 1'b1);
        wait_res(cyc);
        check("clr_next_acc", 32'(bus_u.out_acc), 32'h00003);
        // Pending result discarded by acc_clr in HOLD.
        @(negedge clk);
        acc_clr = 1'b1;
        @(negedge clk);
        acc_clr = 1'b0;
        check("clr_hold_valid", 32'(bus_u.out_valid), 32'd0);
        check("clr_hold_busy", 32'(busy_u), 32'd0);

        // Asynchronous reset while holding a result.
        send(24'h010203, 24'h040506, 1'b1);
        wait_res(cyc);
        check("arst_pre_valid", 32'(bus_u.out_valid), 32'd1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("arst_valid", 32'(bus_u.out_valid), 32'd0);
        check("arst_acc", 32'(bus_u.out_acc), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
